// File: rtl/asteroid_spawner.sv
// asteroid_spawner: frame-stepped spawn/fall/despawn controller for the asteroid slots,
// seeding spawn column and fall speed from the rng and counting dodged asteroids.
module asteroid_spawner #(
  parameter int NUM_SLOTS    = 3,
  parameter int SPAWN_PERIOD = 40,
  parameter int X_MIN        = 100,
  parameter int Y_START      = 0,
  parameter int Y_LIMIT      = 480,
  parameter int SPRITE_H     = 37
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_tick,
  input  logic                   halt,
  input  logic                   restart,
  input  logic [4:0]             random,
  output logic [10*NUM_SLOTS-1:0] ast_x,
  output logic [10*NUM_SLOTS-1:0] ast_y,
  output logic [NUM_SLOTS-1:0]   ast_active,
  output logic                   dodge_pulse,
  output logic [7:0]             dodged_count
);
  localparam int N = NUM_SLOTS;

  if (N < 1 || N > 8 || SPAWN_PERIOD < 1 || SPAWN_PERIOD > 255 || SPRITE_H < 1) begin : g_bad_params
    $error("asteroid_spawner: parameter out of range");
  end

  logic [9:0]   x_q [N];
  logic [9:0]   x_d [N];
  logic [9:0]   y_q [N];
  logic [9:0]   y_d [N];
  logic [2:0]   spd_q [N];
  logic [2:0]   spd_d [N];
  logic [N-1:0] act_q, act_d;
  logic [7:0]   spawn_q, spawn_d, cnt_q, cnt_d;
  logic         dodge_q, dodge_d;
  logic [10:0]  ny;
  logic [3:0]   ndodge;
  logic [8:0]   sum;
  logic         found;

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    spd_d   = spd_q;
    act_d   = act_q;
    spawn_d = spawn_q;
    cnt_d   = cnt_q;
    dodge_d = 1'b0;
    ny      = '0;
    ndodge  = '0;
    sum     = '0;
    found   = 1'b0;
    if (frame_tick && !halt) begin
      for (int i = 0; i < N; i++) begin
        if (act_q[i]) begin
          ny = {1'b0, y_q[i]} + 11'(spd_q[i]);
          if (ny >= 11'(Y_LIMIT)) begin
            act_d[i] = 1'b0;
            ndodge   = ndodge + 4'd1;
          end else begin
            y_d[i] = ny[9:0];
          end
        end
      end
      spawn_d = (spawn_q == 8'd0) ? 8'(SPAWN_PERIOD - 1) : spawn_q - 8'd1;
      // Free slots are judged after this tick's despawns, so a just-freed slot is reusable.
      if (spawn_q == 8'd0) begin
        for (int i = 0; i < N; i++) begin
          if (!act_d[i] && !found) begin
            found    = 1'b1;
            act_d[i] = 1'b1;
            x_d[i]   = 10'(X_MIN) + {2'b00, random, 3'b000};
            y_d[i]   = 10'(Y_START);
            spd_d[i] = {1'b0, random[1:0]} + 3'd1;
          end
        end
      end
      sum     = {1'b0, cnt_q} + 9'(ndodge);
      cnt_d   = sum[8] ? 8'hFF : sum[7:0];
      dodge_d = ndodge != 4'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset || restart) begin
      for (int i = 0; i < N; i++) begin
        x_q[i]   <= '0;
        y_q[i]   <= '0;
        spd_q[i] <= '0;
      end
      act_q   <= '0;
      spawn_q <= 8'(SPAWN_PERIOD - 1);
      cnt_q   <= '0;
      dodge_q <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      spd_q   <= spd_d;
      act_q   <= act_d;
      spawn_q <= spawn_d;
      cnt_q   <= cnt_d;
      dodge_q <= dodge_d;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_out
    assign ast_x[10*g +: 10] = x_q[g];
    assign ast_y[10*g +: 10] = y_q[g];
  end
  assign ast_active   = act_q;
  assign dodge_pulse  = dodge_q;
  assign dodged_count = cnt_q;
endmodule

// File: tb/tb_asteroid_spawner.sv
// tb_asteroid_spawner: directed stimulus against a frame-level model of the slot rules.
module tb_asteroid_spawner;
  localparam int NS = 3;
  localparam int PER = 40;
  localparam int LIM = 480;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic frame_tick = 1'b0, halt = 1'b0, restart = 1'b0;
  logic [4:0] random = '0;
  logic [10*NS-1:0] ast_x, ast_y;
  logic [NS-1:0] ast_active;
  logic dodge_pulse;
  logic [7:0] dodged_count;

  asteroid_spawner #(.NUM_SLOTS(NS), .SPAWN_PERIOD(PER), .X_MIN(100), .Y_START(0),
                     .Y_LIMIT(LIM), .SPRITE_H(37)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .halt(halt), .restart(restart),
    .random(random), .ast_x(ast_x), .ast_y(ast_y), .ast_active(ast_active),
    .dodge_pulse(dodge_pulse), .dodged_count(dodged_count));

  always #20 clk = ~clk;

  int total = 0, bad = 0;
  int mx[NS], my[NS], ms[NS];
  bit ma[NS];
  int mtk = 0, mcnt = 0;
  bit md = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NS; i++) begin
      mx[i] = 0; my[i] = 0; ms[i] = 0; ma[i] = 0;
    end
    mtk = 0; mcnt = 0; md = 0;
  endtask

  task automatic model_update(input bit ft, input bit h, input bit rs, input int rnd);
    int n;
    bit found;
    if (!reset || rs) model_clear();
    else if (h || !ft) md = 0;
    else begin
      mtk++;
      n = 0;
      for (int i = 0; i < NS; i++)
        if (ma[i]) begin
          if (my[i] + ms[i] >= LIM) begin ma[i] = 0; n++; end
          else my[i] += ms[i];
        end
      found = 0;
      if (mtk % PER == 0)
        for (int i = 0; i < NS; i++)
          if (!ma[i] && !found) begin
            found = 1; ma[i] = 1; mx[i] = 100 + rnd * 8; my[i] = 0; ms[i] = rnd % 4 + 1;
          end
      mcnt = (mcnt + n > 255) ? 255 : mcnt + n;
      md = n > 0;
    end
  endtask

  task automatic check_all();
    logic [10*NS-1:0] ex, ey;
    logic [NS-1:0] ea;
    for (int i = 0; i < NS; i++) begin
      ex[10*i +: 10] = 10'(mx[i]);
      ey[10*i +: 10] = 10'(my[i]);
      ea[i] = ma[i];
    end
    chk("model_x", 32'(ast_x), 32'(ex));
    chk("model_y", 32'(ast_y), 32'(ey));
    chk("model_active", 32'(ast_active), 32'(ea));
    chk("model_dodge", 32'(dodge_pulse), 32'(md));
    chk("model_count", 32'(dodged_count), 32'(mcnt));
  endtask

  task automatic step(input bit ft, input bit h, input bit rs, input int rnd);
    #1;
    frame_tick = ft; halt = h; restart = rs; random = 5'(rnd);
    @(posedge clk);
    model_update(ft, h, rs, rnd);
    @(negedge clk);
    check_all();
  endtask

  task automatic ticks(input int k, input int rnd);
    for (int i = 0; i < k; i++) begin
      step(1, 0, 0, rnd);
      step(0, 0, 0, rnd);
    end
  endtask

  initial begin
    model_clear();
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    chk("reset_active", 32'(ast_active), 32'd0);
    chk("reset_count", 32'(dodged_count), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    chk("idle_x", 32'(ast_x), 32'd0);
    chk("idle_active", 32'(ast_active), 32'd0);

    ticks(39, 3);
    chk("pre_spawn_active", 32'(ast_active), 32'd0);
    ticks(1, 3);
    chk("spawn_active", 32'(ast_active), 32'b001);
    chk("spawn_x", 32'(ast_x), 32'd124);
    chk("spawn_y", 32'(ast_y[9:0]), 32'd0);

    ticks(119, 3);
    chk("fall_y476", 32'(ast_y[9:0]), 32'd476);
    step(1, 0, 0, 3);
    chk("despawn_pulse", 32'(dodge_pulse), 32'd1);
    chk("despawn_count", 32'(dodged_count), 32'd1);
    chk("reuse_slot0_y", 32'(ast_y), 32'({10'd160, 10'd320, 10'd0}));
    step(0, 0, 0, 3);
    chk("pulse_one_cycle", 32'(dodge_pulse), 32'd0);

    for (int i = 0; i < 10; i++) begin
      step(1, 1, 0, 3);
      step(0, 1, 0, 3);
    end
    chk("halt_y", 32'(ast_y), 32'({10'd160, 10'd320, 10'd0}));
    chk("halt_count", 32'(dodged_count), 32'd1);

    step(1, 1, 1, 3);
    chk("restart_active", 32'(ast_active), 32'd0);
    chk("restart_count", 32'(dodged_count), 32'd0);
    step(0, 0, 0, 0);
    ticks(39, 0);
    chk("restart_reload", 32'(ast_active), 32'd0);
    ticks(1, 0);
    chk("exh_first_x", 32'(ast_x), 32'd100);
    ticks(120, 0);
    chk("exh_active", 32'(ast_active), 32'b111);
    chk("exh_x", 32'(ast_x), 32'({10'd100, 10'd100, 10'd100}));
    chk("exh_y", 32'(ast_y), 32'({10'd40, 10'd80, 10'd120}));

    step(0, 0, 1, 31);
    ticks(10560, 31);
    chk("saturate", 32'(dodged_count), 32'd255);

    #1 reset = 1'b0;
    #1;
    chk("async_active", 32'(ast_active), 32'd0);
    chk("async_x", 32'(ast_x), 32'd0);
    chk("async_y", 32'(ast_y), 32'd0);
    chk("async_count", 32'(dodged_count), 32'd0);
    model_clear();
    step(1, 0, 0, 31);
    step(0, 0, 0, 31);
    reset = 1'b1;
    ticks(3, 31);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
